// File: rtl/serial_tx_frame.sv
// serial_tx_frame: framed serial transmitter.
// Accepts a DATA_W-bit word over valid/ready and sends it as
// start bit (0), data bits LSB-first, optional parity, stop bit (1),
// each bit held for CLKS_PER_BIT clocks. The line idles high.
// Optional feature: define SERIAL_TX_PARITY_EN to insert an even-parity
// bit between the last data bit and the stop bit.
module serial_tx_frame #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out,
   output logic              busy
);

   // Divider and bit counter keep at least one bit so CLKS_PER_BIT=1 and
   // DATA_W=1 still elaborate; with one bit the "last" compare is always true.
   localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t              r_state;
   logic [DIV_W-1:0]    r_div;
   logic [BIT_W-1:0]    r_bit;
   logic [DATA_W-1:0]   r_shift;
   logic                r_out;
   logic                r_busy;
`ifdef SERIAL_TX_PARITY_EN
   logic                r_parity;
`endif

   logic                w_div_last;
   logic                w_accept;
   logic [DATA_W-1:0]   w_shift_next;

   assign w_div_last   = (r_div == DIV_LAST);
   assign w_accept     = in_valid && (r_state == S_IDLE);
   assign w_shift_next = r_shift >> 1;

   assign in_ready = (r_state == S_IDLE);
   assign out      = r_out;
   assign busy     = r_busy;

   // Frame sequencer: state, divider, bit counter, shift register and the
   // registered line/busy outputs all advance together on each clock.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_div    <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_out    <= 1'b1;
         r_busy   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_out  <= 1'b1;
               r_busy <= 1'b0;
               if (w_accept) begin
                  // Start bit goes on the line the cycle after accept.
                  r_state  <= S_START;
                  r_shift  <= in_data;
                  r_div    <= '0;
                  r_bit    <= '0;
                  r_out    <= 1'b0;
                  r_busy   <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                  r_parity <= ^in_data;
`endif
               end
            end
            S_START: begin
               if (w_div_last) begin
                  r_state <= S_DATA;
                  r_div   <= '0;
                  r_out   <= r_shift[0];
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            S_DATA: begin
               if (w_div_last) begin
                  r_div <= '0;
                  if (r_bit == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_out   <= r_parity;
`else
                     r_state <= S_STOP;
                     r_out   <= 1'b1;
`endif
                  end else begin
                     // Present the next bit in the same edge the word shifts.
                     r_bit   <= r_bit + BIT_W'(1);
                     r_shift <= w_shift_next;
                     r_out   <= w_shift_next[0];
                  end
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
               if (w_div_last) begin
                  r_state <= S_STOP;
                  r_div   <= '0;
                  r_out   <= 1'b1;
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
`endif
            S_STOP: begin
               if (w_div_last) begin
                  // busy drops and in_ready rises on the first IDLE cycle.
                  r_state <= S_IDLE;
                  r_div   <= '0;
                  r_out   <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_div   <= '0;
               r_out   <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx_frame.sv
// Testbench for serial_tx_frame: two instances (CLKS_PER_BIT=4 and 1),
// a table of known words with hand-derived frames, hand-written corner
// sequences and random words checked against a frame model.
module tb_serial_tx_frame;

`ifdef SERIAL_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk;
   logic       resetn;
   logic       tb_valid;
   logic       tb_all;
   logic       tb_sel;
   logic [7:0] tb_data;

   logic       v4, v1;
   logic       rdy4, out4, busy4;
   logic       rdy1, out1, busy1;
   logic       w_out, w_busy, w_rdy;

   int n_cmp = 0;
   int n_bad = 0;

   assign v4     = tb_valid & (~tb_sel | tb_all);
   assign v1     = tb_valid & (tb_sel | tb_all);
   assign w_out  = tb_sel ? out1  : out4;
   assign w_busy = tb_sel ? busy1 : busy4;
   assign w_rdy  = tb_sel ? rdy1  : rdy4;

   serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut4 (
      .clk(clk), .resetn(resetn), .in_valid(v4), .in_data(tb_data),
      .in_ready(rdy4), .out(out4), .busy(busy4));

   serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
      .clk(clk), .resetn(resetn), .in_valid(v1), .in_data(tb_data),
      .in_ready(rdy1), .out(out1), .busy(busy1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] d;
      logic [9:0] frame;   // transmitted bit k is frame[k] (start..stop)
      logic       par;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [9:0] fr, input logic par, input int j);
      if (j < 9) return fr[j];
      if (PAR == 1 && j == 9) return par;
      return fr[9];
   endfunction

   // Wait for in_ready, present the word for one rising edge.
   task automatic accept(input logic [7:0] d, input bit keep);
      int t = 0;
      @(negedge clk);
      while (!w_rdy && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("ready_before_accept", {31'b0, w_rdy}, 1);
      tb_valid = 1'b1;
      tb_data  = d;
      @(posedge clk);
      #1;
      tb_data = 8'($urandom);
      if (!keep) tb_valid = 1'b0;
   endtask

   // Check every cycle of the frame, then the idle gap cycle.
   task automatic check_frame(input logic [9:0] fr, input logic par, input string nm);
      int c = tb_sel ? 1 : 4;
      int f = (10 + PAR) * c;
      for (int k = 0; k < f; k++) begin
         @(negedge clk);
         chk($sformatf("%s_out_c%0d", nm, k), {31'b0, w_out}, {31'b0, exp_bit(fr, par, k / c)});
         chk($sformatf("%s_busyrdy_c%0d", nm, k), {30'b0, w_busy, w_rdy}, 32'b10);
      end
      @(negedge clk);
      chk($sformatf("%s_gap", nm), {29'b0, w_out, w_busy, w_rdy}, 32'b101);
   endtask

   vec_t vecs[9];

   initial begin
      logic [7:0] rd;
      vecs[0] = '{8'hA5, 10'h34A, 1'b0};
      vecs[1] = '{8'h01, 10'h202, 1'b1};
      vecs[2] = '{8'h3C, 10'h278, 1'b0};
      vecs[3] = '{8'hFF, 10'h3FE, 1'b0};
      vecs[4] = '{8'h81, 10'h302, 1'b0};
      vecs[5] = '{8'h55, 10'h2AA, 1'b0};
      vecs[6] = '{8'h0F, 10'h21E, 1'b0};
      vecs[7] = '{8'h07, 10'h20E, 1'b1};
      vecs[8] = '{8'h00, 10'h200, 1'b0};

      // Reset held with in_valid high on both instances.
      resetn   = 1'b0;
      tb_valid = 1'b1;
      tb_all   = 1'b1;
      tb_sel   = 1'b0;
      tb_data  = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("reset4_%0d", i), {29'b0, out4, busy4, rdy4}, 32'b101);
         chk($sformatf("reset1_%0d", i), {29'b0, out1, busy1, rdy1}, 32'b101);
      end
      tb_valid = 1'b0;
      resetn   = 1'b1;
      @(negedge clk);
      chk("post_reset4", {29'b0, out4, busy4, rdy4}, 32'b101);
      chk("post_reset1", {29'b0, out1, busy1, rdy1}, 32'b101);
      tb_all = 1'b0;

      // Table of known words on both divider settings.
      for (int s = 0; s < 2; s++) begin
         tb_sel = s[0];
         for (int i = 0; i < 9; i++) begin
            accept(vecs[i].d, 1'b0);
            check_frame(vecs[i].frame, vecs[i].par, $sformatf("tbl_s%0d_%02h", s, vecs[i].d));
         end
      end

      // Back-to-back with in_valid held: 3C then FF, data changed mid-frame.
      tb_sel = 1'b0;
      accept(8'h3C, 1'b1);
      tb_data = 8'hFF;
      check_frame(10'h278, 1'b0, "b2b_3C");
      @(posedge clk);
      #1;
      tb_valid = 1'b0;
      tb_data  = 8'h00;
      check_frame(10'h3FE, 1'b0, "b2b_FF");

      // Request during DATA is ignored; no extra frame follows.
      accept(8'h81, 1'b0);
      fork
         check_frame(10'h302, 1'b0, "ign_81");
         begin
            repeat (16) @(negedge clk);
            tb_valid = 1'b1;
            tb_data  = 8'h00;
            @(negedge clk);
            tb_valid = 1'b0;
         end
      join
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("ign_idle_%0d", i), {29'b0, w_out, w_busy, w_rdy}, 32'b101);
      end

      // Asynchronous reset during data bit 3 of 0F, between clock edges.
      accept(8'h0F, 1'b0);
      repeat (17) @(negedge clk);
      #2;
      chk("rst_pre_busy", {31'b0, w_busy}, 1);
      resetn = 1'b0;
      #1;
      chk("rst_async", {29'b0, w_out, w_busy, w_rdy}, 32'b101);
      @(negedge clk);
      @(negedge clk);
      chk("rst_held", {29'b0, w_out, w_busy, w_rdy}, 32'b101);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_release", {29'b0, w_out, w_busy, w_rdy}, 32'b101);
      accept(8'h55, 1'b0);
      check_frame(10'h2AA, 1'b0, "rst_then_55");

      // Random words against the frame model, alternating instances.
      for (int i = 0; i < 16; i++) begin
         tb_sel = i[0];
         rd = 8'($urandom_range(0, 255));
         accept(rd, 1'b0);
         check_frame({1'b1, rd, 1'b0}, ^rd, $sformatf("rnd%0d_%02h", i, rd));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
